rcc_dom_rst_seq: RTL and testbench
==================================

// Module: rcc_dom_rst_seq
// PURPOSE
//  Reset/clock sequencer for the D1 and D2 power domains inside the RCC. It takes
//  domain and system reset requests and drives each domain's reset and clock enable in
//  order: gate clock, assert reset, release reset, then re-enable the clock. D2 never
//  leaves reset while D1 is not running. Outputs feed the clock gates and reset
//  synchronisers of rcc_vcore_top.
// PARAMETERS
//  D1_RST_DURATION              10  cycles d1_rst_n is held low (>=1)
//  D2_RST_DURATION              10  cycles d2_rst_n is held low (>=1)
//  CLK_ON_AFTER_D1_RST_RELEASE   8  cycles from d1_rst_n rise to d1_clk_en rise (>=1)
//  CLK_ON_AFTER_D2_RST_RELEASE   8  cycles from d2_rst_n rise to d2_clk_en rise (>=1)
// PORTS
//  clk           in   1  RCC kernel clock
//  rst_n         in   1  asynchronous active-low reset (power-on)
//  sys_rst_req   in   1  level; resets both domains while high
//  d1_rst_req    in   1  level; resets D1 (and therefore D2) while high
//  d2_rst_req    in   1  level; resets D2 only while high
//  d1_pwr_rdy    in   1  D1 supply good; D1 cannot leave ASSERT while low
//  d2_pwr_rdy    in   1  D2 supply good; D2 cannot leave ASSERT while low
//  flag_clr      in   1  pulse; clears both sticky flags
//  d1_rst_n      out  1  D1 reset, active low
//  d2_rst_n      out  1  D2 reset, active low
//  d1_clk_en     out  1  D1 clock-gate enable
//  d2_clk_en     out  1  D2 clock-gate enable
//  d1_rst_flag   out  1  sticky: D1 went through ASSERT since the last clear
//  d2_rst_flag   out  1  sticky: D2 went through ASSERT since the last clear
//  busy          out  1  either FSM not in RUN
// BEHAVIOUR
//  - Per domain FSM {GATE, ASSERT, RELEASE, RUN}; a counter sized by $clog2(max param+1).
//  - Reset (rst_n=0): both FSMs in ASSERT with counter=0. Outputs: rst_n=0, clk_en=0,
//    flags=1, busy=1. Power-on therefore runs the full release sequence.
//  - Effective requests: D1 = sys_rst_req|d1_rst_req;
//    D2 = sys_rst_req|d2_rst_req|(D1 FSM != RUN).
//  - RUN (rst_n=1, clk_en=1): request high -> GATE.
//  - GATE (rst_n=1, clk_en=0): lasts 1 cycle, unconditionally -> ASSERT with counter=0.
//    The clock is stopped before reset asserts.
//  - ASSERT (rst_n=0, clk_en=0): counter counts up each cycle. It leaves to RELEASE when
//    counter==DUR-1, request low and pwr_rdy high; otherwise counter saturates at DUR-1.
//    Request high restarts counter at 0. Low time is therefore >= DUR cycles.
//  - RELEASE (rst_n=1, clk_en=0): counts CLK_ON_AFTER cycles, then -> RUN. Request high
//    (or pwr_rdy low) -> ASSERT with counter=0; rst_n may then glitch low again. That is
//    legal.
//  - D1 leaving RUN forces D2 into GATE the next cycle. If D2 is in RELEASE it goes to
//    ASSERT directly.
//  - Same-cycle events: a request wins over counter expiry. flag set (entry to ASSERT)
//    wins over flag_clr.
//  - All outputs are registered (decoded from state flops); no combinational path from
//    inputs to outputs.
//  - Mid-operation rst_n assertion returns both FSMs to ASSERT immediately (async).
//  - busy = !(d1 RUN && d2 RUN).
// TESTING
//  1 POR, defaults, pwr_rdy=1, no requests -> d1_rst_n rises after 10 cycles,
//    d1_clk_en 8 later. D2 stays in ASSERT until D1 reaches RUN, then +10 rst_n +8 clk_en.
//    busy falls with d2_clk_en.
//  2 From RUN, 1-cycle d2_rst_req -> d2_clk_en=0 at +1, d2_rst_n=0 for 10 cycles from
//    +2, clk_en back 8 after release. D1 outputs unchanged; d2_rst_flag=1, d1_rst_flag=0.
//  3 From RUN, pulse d1_rst_req -> both clk_en drop; D1 sequences as in 1. D2 rst_n stays
//    low until D1 is RUN, then takes 10+8 more cycles.
//  4 Hold sys_rst_req 25 cycles -> both rst_n low for the whole request plus 10 cycles
//    after it falls.
//    Re-raise sys_rst_req during D1 RELEASE -> D1 back to ASSERT, clk_en never glitches.
//  5 Drop d1_pwr_rdy during ASSERT for 30 cycles -> d1_rst_n held low until pwr_rdy
//    returns (the 10 cycles have already elapsed), rises next cycle.
//  6 flag_clr in the same cycle as D2 entering ASSERT -> d2_rst_flag stays 1.
//    rst_n pulse mid-RELEASE -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/rcc_dom_rst_seq.sv
// rcc_dom_rst_seq: reset/clock-enable sequencer for the D1 and D2 power domains.
// Each domain gates its clock, holds reset, releases reset, then re-enables its clock.

module rcc_dom_fsm #(
    parameter int RST_DURATION = 10,
    parameter int CLK_ON_AFTER = 8,
    parameter int CNT_W        = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic pwr_rdy,
    input  logic flag_clr,
    output logic dom_rst_n,
    output logic clk_en,
    output logic rst_flag,
    output logic in_run,
    output logic run_nxt
);
    // state   | meaning
    // GATE    | clock stopped, reset not yet asserted (one cycle)
    // ASSERT  | reset low; leaves once held RST_DURATION cycles, request low, supply good
    // RELEASE | reset high, clock still gated for CLK_ON_AFTER cycles
    // RUN     | reset high, clock enabled

    typedef enum logic [1:0] {
        ST_GATE,
        ST_ASSERT,
        ST_RELEASE,
        ST_RUN
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_DURATION - 1);
    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(CLK_ON_AFTER - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             flag_set;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_RUN: begin
                if (req) state_nxt = ST_GATE;
            end
            ST_GATE: begin
                state_nxt = ST_ASSERT;
                cnt_nxt   = '0;
            end
            ST_ASSERT: begin
                // counter saturates at RST_LAST while waiting for supply or request drop
                if (req) begin
                    cnt_nxt = '0;
                end else if (cnt == RST_LAST) begin
                    if (pwr_rdy) begin
                        state_nxt = ST_RELEASE;
                        cnt_nxt   = '0;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                if (req || !pwr_rdy) begin
                    state_nxt = ST_ASSERT;
                    cnt_nxt   = '0;
                end else if (cnt == ON_LAST) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_ASSERT;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign flag_set = (state_nxt == ST_ASSERT) && (state != ST_ASSERT);
    assign in_run   = (state == ST_RUN);
    assign run_nxt  = (state_nxt == ST_RUN);

    // outputs are flops loaded from the next state so the clock gates see clean levels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_ASSERT;
            cnt       <= '0;
            dom_rst_n <= 1'b0;
            clk_en    <= 1'b0;
            rst_flag  <= 1'b1;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            dom_rst_n <= (state_nxt != ST_ASSERT);
            clk_en    <= (state_nxt == ST_RUN);
            if (flag_set) begin
                rst_flag <= 1'b1;
            end else if (flag_clr) begin
                rst_flag <= 1'b0;
            end
        end
    end
endmodule

module rcc_dom_rst_seq #(
    parameter int D1_RST_DURATION             = 10,
    parameter int D2_RST_DURATION             = 10,
    parameter int CLK_ON_AFTER_D1_RST_RELEASE = 8,
    parameter int CLK_ON_AFTER_D2_RST_RELEASE = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sys_rst_req,
    input  logic d1_rst_req,
    input  logic d2_rst_req,
    input  logic d1_pwr_rdy,
    input  logic d2_pwr_rdy,
    input  logic flag_clr,
    output logic d1_rst_n,
    output logic d2_rst_n,
    output logic d1_clk_en,
    output logic d2_clk_en,
    output logic d1_rst_flag,
    output logic d2_rst_flag,
    output logic busy
);
    localparam int MAX_RST = (D1_RST_DURATION > D2_RST_DURATION) ?
                             D1_RST_DURATION : D2_RST_DURATION;
    localparam int MAX_ON  = (CLK_ON_AFTER_D1_RST_RELEASE > CLK_ON_AFTER_D2_RST_RELEASE) ?
                             CLK_ON_AFTER_D1_RST_RELEASE : CLK_ON_AFTER_D2_RST_RELEASE;
    localparam int MAX_P   = (MAX_RST > MAX_ON) ? MAX_RST : MAX_ON;
    localparam int CNT_W   = (MAX_P < 1) ? 1 : $clog2(MAX_P + 1);

    logic d1_req, d2_req;
    logic d1_in_run, d2_in_run;
    logic d1_run_nxt, d2_run_nxt;

    // D2 is held in reset whenever D1 is anywhere but RUN
    assign d1_req = sys_rst_req | d1_rst_req;
    assign d2_req = sys_rst_req | d2_rst_req | ~d1_in_run;

    rcc_dom_fsm #(
        .RST_DURATION (D1_RST_DURATION),
        .CLK_ON_AFTER (CLK_ON_AFTER_D1_RST_RELEASE),
        .CNT_W        (CNT_W)
    ) u_d1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (d1_req),
        .pwr_rdy   (d1_pwr_rdy),
        .flag_clr  (flag_clr),
        .dom_rst_n (d1_rst_n),
        .clk_en    (d1_clk_en),
        .rst_flag  (d1_rst_flag),
        .in_run    (d1_in_run),
        .run_nxt   (d1_run_nxt)
    );

    rcc_dom_fsm #(
        .RST_DURATION (D2_RST_DURATION),
        .CLK_ON_AFTER (CLK_ON_AFTER_D2_RST_RELEASE),
        .CNT_W        (CNT_W)
    ) u_d2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (d2_req),
        .pwr_rdy   (d2_pwr_rdy),
        .flag_clr  (flag_clr),
        .dom_rst_n (d2_rst_n),
        .clk_en    (d2_clk_en),
        .rst_flag  (d2_rst_flag),
        .in_run    (d2_in_run),
        .run_nxt   (d2_run_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b1;
        end else begin
            busy <= !(d1_run_nxt && d2_run_nxt);
        end
    end

    // d2_in_run is kept for symmetry with D1; only the D1 decode feeds a request
    logic unused_d2_in_run;
    assign unused_d2_in_run = d2_in_run;
endmodule

// File: tb/tb_rcc_dom_rst_seq.sv
// Bench for rcc_dom_rst_seq: directed sequencing scenarios plus random stimulus,
// checked against an output-level model of the domain sequencing rules.

module tb_rcc_dom_rst_seq;
    localparam int D1_RST = 10;
    localparam int D2_RST = 10;
    localparam int D1_ON  = 8;
    localparam int D2_ON  = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic sys_rst_req = 1'b0, d1_rst_req = 1'b0, d2_rst_req = 1'b0;
    logic d1_pwr_rdy = 1'b1, d2_pwr_rdy = 1'b1, flag_clr = 1'b0;
    logic d1_rst_n, d2_rst_n, d1_clk_en, d2_clk_en, d1_rst_flag, d2_rst_flag, busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    rcc_dom_rst_seq #(
        .D1_RST_DURATION             (D1_RST),
        .D2_RST_DURATION             (D2_RST),
        .CLK_ON_AFTER_D1_RST_RELEASE (D1_ON),
        .CLK_ON_AFTER_D2_RST_RELEASE (D2_ON)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sys_rst_req (sys_rst_req),
        .d1_rst_req  (d1_rst_req),
        .d2_rst_req  (d2_rst_req),
        .d1_pwr_rdy  (d1_pwr_rdy),
        .d2_pwr_rdy  (d2_pwr_rdy),
        .flag_clr    (flag_clr),
        .d1_rst_n    (d1_rst_n),
        .d2_rst_n    (d2_rst_n),
        .d1_clk_en   (d1_clk_en),
        .d2_clk_en   (d2_clk_en),
        .d1_rst_flag (d1_rst_flag),
        .d2_rst_flag (d2_rst_flag),
        .busy        (busy)
    );

    // model: per domain the output levels, a pending-gate marker and elapsed-time counts
    bit m_rst[2];
    bit m_clk[2];
    bit m_gate[2];
    bit m_flag[2];
    int m_low[2];
    int m_hi[2];
    int rst_dur[2] = '{D1_RST, D2_RST};
    int on_dur[2]  = '{D1_ON, D2_ON};

    localparam logic [6:0] RESET_VEC = 7'b0000111;

    function automatic logic [6:0] dut_vec();
        return {d1_rst_n, d2_rst_n, d1_clk_en, d2_clk_en, d1_rst_flag, d2_rst_flag, busy};
    endfunction

    function automatic logic [6:0] mdl_vec();
        return {m_rst[0], m_rst[1], m_clk[0], m_clk[1], m_flag[0], m_flag[1],
                !(m_clk[0] && m_clk[1])};
    endfunction

    task automatic mdl_reset();
        for (int d = 0; d < 2; d++) begin
            m_rst[d] = 1'b0; m_clk[d] = 1'b0; m_gate[d] = 1'b0;
            m_flag[d] = 1'b1; m_low[d] = 0; m_hi[d] = 0;
        end
    endtask

    task automatic dom_step(input int d, input bit req, input bit pwr, output bit set);
        set = 1'b0;
        if (m_clk[d]) begin
            if (req) begin m_clk[d] = 1'b0; m_gate[d] = 1'b1; end
        end else if (m_gate[d]) begin
            m_gate[d] = 1'b0; m_rst[d] = 1'b0; m_low[d] = 0; set = 1'b1;
        end else if (!m_rst[d]) begin
            if (req) m_low[d] = 0;
            else if (m_low[d] >= rst_dur[d] - 1 && pwr) begin m_rst[d] = 1'b1; m_hi[d] = 0; end
            else m_low[d]++;
        end else begin
            if (req || !pwr) begin m_rst[d] = 1'b0; m_low[d] = 0; set = 1'b1; end
            else if (m_hi[d] >= on_dur[d] - 1) m_clk[d] = 1'b1;
            else m_hi[d]++;
        end
    endtask

    task automatic model_step();
        bit e1, e2, s1, s2;
        e1 = sys_rst_req | d1_rst_req;
        e2 = sys_rst_req | d2_rst_req | !m_clk[0];
        dom_step(0, e1, d1_pwr_rdy, s1);
        dom_step(1, e2, d2_pwr_rdy, s2);
        m_flag[0] = s1 ? 1'b1 : (flag_clr ? 1'b0 : m_flag[0]);
        m_flag[1] = s2 ? 1'b1 : (flag_clr ? 1'b0 : m_flag[1]);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic settle();
        for (int k = 0; k < 200 && !(m_clk[0] && m_clk[1]); k++) step();
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        mdl_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (dut_vec() !== RESET_VEC) begin
            n_errors++;
            $display("FAIL reset_outputs got %b want %b", dut_vec(), RESET_VEC);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_por();
        int t_d1r = -1, t_d1c = -1, t_d2r = -1, t_d2c = -1, t_busy = -1;
        for (int k = 1; k <= 60; k++) begin
            step();
            n_checks++;
            if (dut_vec() !== mdl_vec()) begin
                n_errors++;
                $display("FAIL por_cycle%0d got %b want %b", k, dut_vec(), mdl_vec());
            end
            if (t_d1r < 0 && d1_rst_n === 1'b1) t_d1r = k;
            if (t_d1c < 0 && d1_clk_en === 1'b1) t_d1c = k;
            if (t_d2r < 0 && d2_rst_n === 1'b1) t_d2r = k;
            if (t_d2c < 0 && d2_clk_en === 1'b1) t_d2c = k;
            if (t_busy < 0 && busy === 1'b0) t_busy = k;
        end
        n_checks++;
        if (t_d1r != D1_RST) begin
            n_errors++; $display("FAIL por_d1_rst_rise got %0d want %0d", t_d1r, D1_RST);
        end
        n_checks++;
        if (t_d1c != D1_RST + D1_ON) begin
            n_errors++; $display("FAIL por_d1_clk_rise got %0d want %0d", t_d1c, D1_RST + D1_ON);
        end
        n_checks++;
        if (t_d2r != D1_RST + D1_ON + D2_RST) begin
            n_errors++;
            $display("FAIL por_d2_rst_rise got %0d want %0d", t_d2r, D1_RST + D1_ON + D2_RST);
        end
        n_checks++;
        if (t_d2c != D1_RST + D1_ON + D2_RST + D2_ON || t_busy != t_d2c) begin
            n_errors++;
            $display("FAIL por_d2_clk_busy got clk=%0d busy=%0d want %0d", t_d2c, t_busy,
                     D1_RST + D1_ON + D2_RST + D2_ON);
        end
    endtask

    task automatic test_d2_req();
        int low = 0, t_r = -1, t_c = -1;
        flag_clr = 1'b1; step(); flag_clr = 1'b0;
        d2_rst_req = 1'b1; step(); d2_rst_req = 1'b0;
        n_checks++;
        if ({d1_rst_n, d1_clk_en, d2_rst_n, d2_clk_en} !== 4'b1110) begin
            n_errors++;
            $display("FAIL d2req_gate got %b want 1110", {d1_rst_n, d1_clk_en, d2_rst_n, d2_clk_en});
        end
        for (int k = 1; k <= 40; k++) begin
            step();
            n_checks++;
            if (dut_vec() !== mdl_vec() || d1_clk_en !== 1'b1 || d1_rst_n !== 1'b1) begin
                n_errors++;
                $display("FAIL d2req_cycle%0d got %b want %b", k, dut_vec(), mdl_vec());
            end
            if (d2_rst_n === 1'b0) low++;
            if (t_r < 0 && d2_rst_n === 1'b1) t_r = k;
            if (t_c < 0 && d2_clk_en === 1'b1) t_c = k;
        end
        n_checks++;
        if (low != D2_RST || t_c - t_r != D2_ON) begin
            n_errors++;
            $display("FAIL d2req_timing got low=%0d on=%0d want %0d %0d", low, t_c - t_r, D2_RST, D2_ON);
        end
        n_checks++;
        if ({d1_rst_flag, d2_rst_flag} !== 2'b01) begin
            n_errors++; $display("FAIL d2req_flags got %b want 01", {d1_rst_flag, d2_rst_flag});
        end
    endtask

    task automatic test_d1_req();
        int low = 0, t_1c = -1, t_2r = -1, t_2c = -1;
        flag_clr = 1'b1; step(); flag_clr = 1'b0;
        d1_rst_req = 1'b1; step(); d1_rst_req = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            step();
            n_checks++;
            if (dut_vec() !== mdl_vec()) begin
                n_errors++;
                $display("FAIL d1req_cycle%0d got %b want %b", k, dut_vec(), mdl_vec());
            end
            if (d1_rst_n === 1'b0) low++;
            if (t_1c < 0 && d1_clk_en === 1'b1) t_1c = k;
            if (t_2r < 0 && t_1c > 0 && d2_rst_n === 1'b1) t_2r = k;
            if (t_2c < 0 && d2_clk_en === 1'b1) t_2c = k;
        end
        n_checks++;
        if (low != D1_RST || t_2r - t_1c != D2_RST || t_2c - t_2r != D2_ON) begin
            n_errors++;
            $display("FAIL d1req_timing got low=%0d d2low=%0d d2on=%0d want %0d %0d %0d",
                     low, t_2r - t_1c, t_2c - t_2r, D1_RST, D2_RST, D2_ON);
        end
        n_checks++;
        if ({d1_rst_flag, d2_rst_flag} !== 2'b11) begin
            n_errors++; $display("FAIL d1req_flags got %b want 11", {d1_rst_flag, d2_rst_flag});
        end
    endtask

    task automatic test_sys_hold();
        int t_rise = -1, t_r = -1, t_c = -1;
        sys_rst_req = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            step();
            n_checks++;
            if (dut_vec() !== mdl_vec() || (i >= 2 && {d1_rst_n, d2_rst_n} !== 2'b00)) begin
                n_errors++;
                $display("FAIL syshold_cycle%0d got %b want %b", i, dut_vec(), mdl_vec());
            end
        end
        sys_rst_req = 1'b0;
        for (int k = 1; k <= 30 && t_rise < 0; k++) begin
            step();
            if (d1_rst_n === 1'b1) t_rise = k;
        end
        n_checks++;
        if (t_rise != D1_RST || d2_rst_n !== 1'b0) begin
            n_errors++;
            $display("FAIL syshold_release got %0d d2=%b want %0d d2=0", t_rise, d2_rst_n, D1_RST);
        end
        repeat (3) step();
        sys_rst_req = 1'b1; step(); sys_rst_req = 1'b0;
        n_checks++;
        if ({d1_rst_n, d1_clk_en} !== 2'b00 || dut_vec() !== mdl_vec()) begin
            n_errors++;
            $display("FAIL sysreraise_assert got %b want %b", dut_vec(), mdl_vec());
        end
        for (int k = 1; k <= 40; k++) begin
            step();
            if (t_r < 0 && d1_rst_n === 1'b1) t_r = k;
            if (t_c < 0 && d1_clk_en === 1'b1) t_c = k;
        end
        n_checks++;
        if (t_r != D1_RST || t_c - t_r != D1_ON) begin
            n_errors++;
            $display("FAIL sysreraise_timing got rst=%0d on=%0d want %0d %0d", t_r, t_c - t_r, D1_RST, D1_ON);
        end
        settle();
    endtask

    task automatic test_pwr_drop();
        d1_rst_req = 1'b1; step(); d1_rst_req = 1'b0;
        repeat (3) step();
        d1_pwr_rdy = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            step();
            n_checks++;
            if (d1_rst_n !== 1'b0 || dut_vec() !== mdl_vec()) begin
                n_errors++;
                $display("FAIL pwrdrop_cycle%0d got %b want %b", i, dut_vec(), mdl_vec());
            end
        end
        d1_pwr_rdy = 1'b1;
        step();
        n_checks++;
        if (d1_rst_n !== 1'b1) begin
            n_errors++; $display("FAIL pwrdrop_release got %b want 1", d1_rst_n);
        end
        settle();
    endtask

    task automatic test_flag_clr();
        flag_clr = 1'b1; step(); flag_clr = 1'b0;
        n_checks++;
        if ({d1_rst_flag, d2_rst_flag} !== 2'b00) begin
            n_errors++; $display("FAIL flagclr_plain got %b want 00", {d1_rst_flag, d2_rst_flag});
        end
        d2_rst_req = 1'b1; step(); d2_rst_req = 1'b0;
        flag_clr = 1'b1; step(); flag_clr = 1'b0;
        n_checks++;
        if ({d1_rst_flag, d2_rst_flag, d2_rst_n} !== 3'b010) begin
            n_errors++;
            $display("FAIL flagclr_collide got %b want 010", {d1_rst_flag, d2_rst_flag, d2_rst_n});
        end
        settle();
    endtask

    task automatic test_async_rst();
        int t_r = -1;
        d2_rst_req = 1'b1; step(); d2_rst_req = 1'b0;
        for (int k = 1; k <= 30 && t_r < 0; k++) begin
            step();
            if (d2_rst_n === 1'b1 && k > 2) t_r = k;
        end
        repeat (3) step();
        n_checks++;
        if ({d2_rst_n, d2_clk_en} !== 2'b10 || dut_vec() !== mdl_vec()) begin
            n_errors++;
            $display("FAIL async_pre got %b want %b", dut_vec(), mdl_vec());
        end
        @(negedge clk);
        rst_n = 1'b0;
        mdl_reset();
        #1;
        n_checks++;
        if (dut_vec() !== RESET_VEC) begin
            n_errors++; $display("FAIL async_reset got %b want %b", dut_vec(), RESET_VEC);
        end
        @(negedge clk);
        rst_n = 1'b1;
        settle();
        n_checks++;
        if (busy !== 1'b0 || dut_vec() !== mdl_vec()) begin
            n_errors++; $display("FAIL async_recover got %b want %b", dut_vec(), mdl_vec());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            sys_rst_req = ($urandom_range(0, 99) < 2);
            d1_rst_req  = ($urandom_range(0, 99) < 3);
            d2_rst_req  = ($urandom_range(0, 99) < 4);
            d1_pwr_rdy  = ($urandom_range(0, 99) < 93);
            d2_pwr_rdy  = ($urandom_range(0, 99) < 93);
            flag_clr    = ($urandom_range(0, 99) < 6);
            step();
            n_checks++;
            if (dut_vec() !== mdl_vec()) begin
                n_errors++;
                $display("FAIL random_cycle%0d got %b want %b", i, dut_vec(), mdl_vec());
            end
        end
        {sys_rst_req, d1_rst_req, d2_rst_req, flag_clr} = 4'b0000;
        d1_pwr_rdy = 1'b1;
        d2_pwr_rdy = 1'b1;
        settle();
        n_checks++;
        if (busy !== 1'b0 || dut_vec() !== mdl_vec()) begin
            n_errors++; $display("FAIL random_settle got %b want %b", dut_vec(), mdl_vec());
        end
    endtask

    initial begin
        test_reset();
        test_por();
        test_d2_req();
        test_d1_req();
        test_sys_hold();
        test_pwr_drop();
        test_flag_clr();
        test_async_rst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "bench time limit");
    end
endmodule
